// File: rtl/multich_cymometer_if.sv
// Bundle of control, input and result signals for the multi-channel cymometer.
// The measuring core takes the slave side; whoever drives start and gate_len
// and consumes the results takes the master side.
interface multich_cymometer_if #(
  parameter int NCH    = 4,
  parameter int CW     = 32,
  parameter int GATE_W = 32
);
  logic              start;
  logic              mode_cont;
  logic [GATE_W-1:0] gate_len;
  logic [NCH-1:0]    fx_in;
  logic              busy;
  logic              done;
  logic [NCH*CW-1:0] fx_cnt;
  logic [NCH*CW-1:0] fs_cnt;
  logic [NCH*CW-1:0] ph_cnt;
  logic [NCH-1:0]    lead;
  logic [NCH-1:0]    ovf;
  logic [NCH-1:0]    nosig;

  modport master (
    output start, mode_cont, gate_len, fx_in,
    input  busy, done, fx_cnt, fs_cnt, ph_cnt, lead, ovf, nosig
  );

  modport slave (
    input  start, mode_cont, gate_len, fx_in,
    output busy, done, fx_cnt, fs_cnt, ph_cnt, lead, ovf, nosig
  );
endinterface

// File: rtl/multich_cymometer.sv
// Multi-channel reciprocal frequency/phase meter, windows aligned to each input's own periods.
// Latency: gate_len cycles + wait for next rising edge per channel (bounded by gate_len timeout) + 2.
// No backpressure: start is dropped while busy; results and done update once per measurement.
module multich_cymometer #(
  parameter int NCH         = 4,
  parameter int CW          = 32,
  parameter int GATE_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input logic                clk_fs,
  input logic                rst,
  multich_cymometer_if.slave cym
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GATE  = 2'd1;
  localparam logic [1:0] ST_CLOSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
  localparam logic [CW-1:0] SAT   = '1;

  logic [NCH-1:0]    sync_q [SYNC_STAGES];
  logic [NCH-1:0]    s_d_q;
  logic [NCH-1:0]    s;
  logic [NCH-1:0]    rise;

  logic [1:0]        state_q, state_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [GATE_W-1:0] tmo_q, tmo_d;
  logic [GATE_W-1:0] len_q, len_d;
  logic [GATE_W-1:0] eff_len;
  logic              clear;
  logic              count_en;

  logic [NCH-1:0]    op_q, cl_q, ph_state_q;
  logic [CW-1:0]     fx_tmp_q [NCH];
  logic [CW-1:0]     fs_tmp_q [NCH];
  logic [CW-1:0]     ph_tmp_q [NCH];

  logic              done_q;
  logic [NCH*CW-1:0] fx_cnt_q, fs_cnt_q, ph_cnt_q;
  logic [NCH-1:0]    lead_q, ovf_q, nosig_q;

  assign s        = sync_q[SYNC_STAGES-1];
  assign rise     = s & ~s_d_q;
  assign eff_len  = (cym.gate_len == '0) ? GATE_W'(1) : cym.gate_len;
  assign clear    = ((state_q == ST_IDLE) && cym.start) || (state_q == ST_DONE);
  assign count_en = (state_q == ST_GATE) || (state_q == ST_CLOSE);

  // Synchroniser chain plus one edge-detect flop per input.
  always_ff @(posedge clk_fs or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      s_d_q <= '0;
    end else begin
      sync_q[0] <= cym.fx_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      s_d_q <= s;
    end
  end

  // Sequencer next state: gate countdown, then wait for all windows to close or the timeout.
  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    tmo_d   = tmo_q;
    len_d   = len_q;
    case (state_q)
      ST_IDLE: begin
        if (cym.start) begin
          gate_d  = eff_len;
          len_d   = eff_len;
          state_d = ST_GATE;
        end
      end
      ST_GATE: begin
        if (gate_q <= GATE_W'(1)) begin
          tmo_d   = len_q;
          state_d = ST_CLOSE;
        end else begin
          gate_d = gate_q - GATE_W'(1);
        end
      end
      ST_CLOSE: begin
        if ((&cl_q) || (tmo_q <= GATE_W'(1))) state_d = ST_DONE;
        else                                  tmo_d   = tmo_q - GATE_W'(1);
      end
      default: begin
        if (cym.mode_cont) begin
          gate_d  = eff_len;
          len_d   = eff_len;
          state_d = ST_GATE;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk_fs or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gate_q  <= '0;
      tmo_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      tmo_q   <= tmo_d;
      len_q   <= len_d;
    end
  end

  // Per-channel window flags, saturating counters and phase-direction tracking.
  always_ff @(posedge clk_fs or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      cl_q       <= '0;
      ph_state_q <= '0;
      for (int k = 0; k < NCH; k++) begin
        fx_tmp_q[k] <= '0;
        fs_tmp_q[k] <= '0;
        ph_tmp_q[k] <= '0;
      end
    end else if (clear) begin
      op_q       <= '0;
      cl_q       <= '0;
      ph_state_q <= '0;
      for (int k = 0; k < NCH; k++) begin
        fx_tmp_q[k] <= '0;
        fs_tmp_q[k] <= '0;
        ph_tmp_q[k] <= '0;
      end
    end else if (count_en) begin
      for (int k = 0; k < NCH; k++) begin
        // The opening rise itself is not counted as a period; the closing rise is.
        if ((state_q == ST_GATE) && !op_q[k] && rise[k]) op_q[k] <= 1'b1;
        if ((state_q == ST_CLOSE) && op_q[k] && !cl_q[k] && rise[k]) cl_q[k] <= 1'b1;
        if (op_q[k] && !cl_q[k]) begin
          if (fs_tmp_q[k] != SAT) fs_tmp_q[k] <= fs_tmp_q[k] + CW'(1);
          if (rise[k] && (fx_tmp_q[k] != SAT)) fx_tmp_q[k] <= fx_tmp_q[k] + CW'(1);
          if ((s[0] != s[k]) && (ph_tmp_q[k] != SAT)) ph_tmp_q[k] <= ph_tmp_q[k] + CW'(1);
        end
        if (s[0] && !s[k])      ph_state_q[k] <= 1'b1;
        else if (s[k] && !s[0]) ph_state_q[k] <= 1'b0;
      end
    end
  end

  // Result registers: published once per measurement, zeroed for channels that never closed.
  always_ff @(posedge clk_fs or posedge rst) begin
    if (rst) begin
      done_q   <= 1'b0;
      fx_cnt_q <= '0;
      fs_cnt_q <= '0;
      ph_cnt_q <= '0;
      lead_q   <= '0;
      ovf_q    <= '0;
      nosig_q  <= '0;
    end else begin
      done_q <= (state_q == ST_DONE);
      if (state_q == ST_DONE) begin
        for (int k = 0; k < NCH; k++) begin
          nosig_q[k] <= !(op_q[k] && cl_q[k]);
          ovf_q[k]   <= (fx_tmp_q[k] == SAT) || (fs_tmp_q[k] == SAT) || (ph_tmp_q[k] == SAT);
          lead_q[k]  <= (k == 0) ? 1'b0 : ph_state_q[k];
          fx_cnt_q[k*CW +: CW] <= (op_q[k] && cl_q[k]) ? fx_tmp_q[k] : '0;
          fs_cnt_q[k*CW +: CW] <= (op_q[k] && cl_q[k]) ? fs_tmp_q[k] : '0;
          ph_cnt_q[k*CW +: CW] <= (op_q[k] && cl_q[k] && (k != 0)) ? ph_tmp_q[k] : '0;
        end
      end
    end
  end

  assign cym.busy   = (state_q != ST_IDLE);
  assign cym.done   = done_q;
  assign cym.fx_cnt = fx_cnt_q;
  assign cym.fs_cnt = fs_cnt_q;
  assign cym.ph_cnt = ph_cnt_q;
  assign cym.lead   = lead_q;
  assign cym.ovf    = ovf_q;
  assign cym.nosig  = nosig_q;

endmodule

// File: doc/multich_cymometer.md
Name: multich_cymometer

Overview:
- Multi-channel, equal-precision (reciprocal) frequency and phase meter.
- Input signals are sampled in the single reference clock domain clk_fs, so no cross-domain counters are needed.
- Each channel's measurement window is aligned to whole periods of its own input, using a shared programmable gate.
- Reports per channel: period count, reference-cycle count and phase-difference count against channel 0, in single-shot or continuous mode.

Parameters:
NCH, 4, number of measured input channels (>=2)
CW, 32, width of every result counter
GATE_W, 32, width of gate_len
SYNC_STAGES, 2, synchroniser flops per input (>=2)

Ports:
clk_fs  in  1  reference clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a measurement; ignored while busy=1
mode_cont  in  1  1 = re-arm automatically after each DONE; sampled in DONE
gate_len  in  GATE_W  gate length in clk_fs cycles; sampled on accepted start; 0 treated as 1
fx_in  in  NCH  asynchronous measured signals
busy  out  1  high from accepted start until return to IDLE
done  out  1  one-cycle pulse when result outputs update
fx_cnt  out  NCH*CW  per-channel whole periods in aligned window (channel k at [k*CW +: CW])
fs_cnt  out  NCH*CW  per-channel clk_fs cycles in aligned window
ph_cnt  out  NCH*CW  per-channel cycles inside window where sync(ch0) != sync(chk); slice 0 always 0
lead  out  NCH  1 = channel 0 leads channel k; bit 0 always 0
ovf  out  NCH  a counter of that channel saturated
nosig  out  NCH  channel window never opened or never closed before timeout

Behaviour:
- Reset: FSM=IDLE; busy=0, done=0; all counters, results, lead, ovf and nosig = 0.
- Input conditioning:
  - fx_in[k] passes through SYNC_STAGES flops, then one edge flop.
  - rise[k] = s & ~s_d. Latency from pin to rise[k] = SYNC_STAGES+1 cycles.
- FSM states:
  - IDLE: on start, load gate_len into the gate counter, clear all temporaries, go to GATE.
  - GATE: gate counter counts down. When it reaches 1, go to CLOSE, and load the timeout counter with the effective gate length.
  - CLOSE: wait until every channel is closed, or the timeout counter expires; then go to DONE.
  - DONE (1 cycle): copy temporaries to outputs and pulse done. If mode_cont=1, reload gate_len and go to GATE; else go to IDLE.
- Per-channel window control (open flag op[k], closed flag cl[k]):
  - Opens on the first rise[k] while in GATE.
  - Closes on the first rise[k] after the FSM leaves GATE.
  - A channel that opens in the last GATE cycle still closes only on a later rise.
- Per-channel counting:
  - While op[k]=1 and cl[k]=0: fs_tmp increments every cycle; fx_tmp increments on each rise[k] after the opening rise, including the closing rise.
  - ph_tmp increments each in-window cycle where s0 != sk.
- Phase direction:
  - ph_state[k] set when s0=1 and sk=0; cleared when sk=1 and s0=0; otherwise held.
  - lead[k] <= ph_state[k] at DONE.
- Saturation: any temporary at all-ones holds its value and sets ovf[k] at DONE.
- Timeout: at DONE, a channel not both opened and closed gets nosig[k]=1, and fx_cnt/fs_cnt/ph_cnt = 0 for that channel.
- Ordering:
  - rst overrides everything.
  - start while busy is dropped; no queuing.
  - mode_cont deasserted mid-run takes effect at the next DONE.
- Invariant: fs_cnt/fx_cnt = exact integer reference-cycle period when the input period is an integer number of cycles.

Test Plan:
- Reset mid-GATE: assert rst while busy=1 -> busy=0 and all outputs 0 asynchronously; next start runs cleanly.
- Frequency: all channels period 10 clk (5 hi/5 lo), gate_len=1000 -> done once; per channel fx_cnt in {100,101}, fs_cnt = 10*fx_cnt, ph_cnt[0]=0, ovf=0, nosig=0.
- Phase: ch1 = ch0 delayed 2 cycles, period 10, gate_len=500 -> ph_cnt[1] = 4*fx_cnt[1] (+/-4), lead[1]=1. Swap delay direction -> lead[1]=0.
- Dead channel: ch2 held low, gate_len=200 -> done after 400 + small constant cycles; nosig[2]=1, ch2 results 0; other channels valid.
- Continuous and overflow:
  - mode_cont=1, gate_len=100, period 8 -> done pulses every ~100-110 cycles with fs_cnt = 8*fx_cnt.
  - With CW=8, period 4, gate_len=400 -> fs_cnt[k]=255, ovf[k]=1.
- Start while busy: second start during GATE -> ignored; exactly one done per accepted start in single-shot mode.
